hack_control: RTL and testbench
===============================

# hack_control

Sequential control unit that drives the Hack 16-bit ALU from the instruction side. It accepts Hack A- and C-instructions over a valid/ready handshake and decodes C-instruction fields into the ALU control bits (zx, nx, zy, ny, f, no). It holds the A, D and PC registers, consumes the ALU result and zr/ng flags, and performs register and memory writeback and jump selection. It sits between the instruction fetch path and the ALU/data-memory pair.

## Interface
Parameters:
- none

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- instr  in  16  Hack instruction; bit 15 = 0 is an A-instruction, 1 is a C-instruction
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  block accepts instr this cycle
- in_m  in  16  data memory read data at address_m; combinational, valid in EXEC
- out_m  out  16  memory write data; equals alu_out
- write_m  out  1  memory write strobe, one cycle
- address_m  out  15  A[14:0]
- pc  out  15  program counter
- alu_x  out  16  D register
- alu_y  out  16  in_m if latched a-bit, else A
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  latched instr[11:6] in that order
- alu_out  in  16  ALU result; combinational from alu_x/alu_y/controls
- alu_zr  in  1  alu_out == 0
- alu_ng  in  1  alu_out[15]

## Operation
- State: A (16b), D (16b), PC (15b), IR (16b latched instruction), FSM {IDLE, EXEC}.
- instr_ready = (state == IDLE) & !reset. Handshake fires on instr_valid & instr_ready.
- IDLE, fire, instr[15] = 0: A <= instr; PC <= PC+1; stay in IDLE. Back-to-back A-instructions run at 1 per cycle.
- IDLE, fire, instr[15] = 1: IR <= instr; go to EXEC. instr[14:13] are ignored.
- IDLE, no fire: all state holds.
- EXEC: ALU controls and alu_y mux come from IR. Fields: a = IR[12], dest = IR[5:3] (A, D, M), jump = IR[2:0] (lt, eq, gt).
  - write_m = IR[3]; D <= alu_out if IR[4]; A <= alu_out if IR[5].
  - jmp = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&!ng&!zr). PC <= jmp ? A[14:0] (pre-write A) : PC+1.
  - Return to IDLE.
- address_m, alu_y and the jump target all use the A value held during EXEC, even when dest includes A. A and D may both be written with the same alu_out.
- PC+1 wraps 0x7FFF -> 0x0000.
- write_m is 0 outside EXEC. A C-instruction with all-zero dest and jump only advances PC.

## Timing
- Reset (any state): A = 0, D = 0, PC = 0, IR = 0, state = IDLE. Outputs: write_m = 0, instr_ready = 0 during reset, pc = 0, address_m = 0, ALU controls = 0, alu_x = 0.
- Reset asserted in EXEC aborts the instruction: no register or memory write, and write_m is 0 in that cycle. Reset has priority over all updates.
- A-instruction latency: 1 cycle, visible on pc/address_m after the accepting edge.
- C-instruction latency: 2 cycles (accept edge, then EXEC edge). instr_ready is low for exactly one cycle.
- in_m and alu_out must settle within the EXEC cycle. The block has no combinational path from instr to any output.

## Configuration
- HACK_CONTROL_RETIRE_CNT_EN defined: adds output retired (32 bits), reset to 0. It increments by 1 on every completed A-instruction (accept edge) and every completed C-instruction (EXEC edge), and wraps at 2^32. An instruction aborted by reset does not increment it.
- HACK_CONTROL_RETIRE_CNT_EN undefined: the retired port and counter do not exist. All other behaviour is identical.

## Test plan
- Reset, then instr = 0x0005 with valid -> next cycle A = 5, address_m = 5, pc = 1, instr_ready stays 1.
- After @5, issue 0xEC10 (D=A) -> EXEC cycle shows controls 110000 and alu_y = 5. Afterwards D = 5, pc = 2, instr_ready low exactly one cycle, write_m never high.
- A = 100, D = 5, issue 0xE7C8 (M=D+1) -> write_m high for exactly one cycle with address_m = 100 and out_m = 6. A and D unchanged, pc advances by 1.
- A = 42, D = 0, issue 0xE302 (D;JEQ) -> pc = 42. Repeat with D = 5 -> pc = old pc+1.
- Issue 0xEC20 (A=A) with IR jump bits set via 0xEC27 (A=A;JMP), A = 7 -> pc = 7 from pre-write A, and A = 7 after.
- Assert reset during EXEC of 0xE7C8 -> write_m = 0 that cycle, then A = D = pc = 0 and instr_ready = 1 the cycle after reset drops. With HACK_CONTROL_RETIRE_CNT_EN, retired = 0.

Source files
------------

// File: rtl/hack_control.sv
// hack_control: Hack CPU control unit; decodes A/C instructions, owns A/D/PC,
// drives the external ALU and performs writeback and jumps.
// Ports: clk, reset (sync, active-high); instr/instr_valid/instr_ready
// handshake; in_m/out_m/write_m/address_m memory side; pc; alu_x/alu_y and
// alu_zx..alu_no to the ALU; alu_out/alu_zr/alu_ng back from it.
// Optional: define HACK_CONTROL_RETIRE_CNT_EN to add the 32-bit retired counter.
module hack_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] in_m,
    output logic [15:0] out_m,
    output logic        write_m,
    output logic [14:0] address_m,
    output logic [14:0] pc,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng
`ifdef HACK_CONTROL_RETIRE_CNT_EN
    ,
    output logic [31:0] retired
`endif
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] d_q, d_d;
    logic [14:0] pc_q, pc_d;
    // instr[15:13] carry no information once a C-instruction is accepted
    logic [12:0] ir_q, ir_d;
    logic        fire;
    logic        jmp;
    logic        retire;

    assign instr_ready = (state_q == IDLE) & ~reset;
    assign fire        = instr_valid & instr_ready;

    assign jmp = (ir_q[2] & alu_ng) |
                 (ir_q[1] & alu_zr) |
                 (ir_q[0] & ~alu_ng & ~alu_zr);

    // Memory write is suppressed in the same cycle reset aborts an EXEC
    assign write_m   = (state_q == EXEC) & ir_q[3] & ~reset;
    assign out_m     = alu_out;
    assign address_m = a_q[14:0];
    assign pc        = pc_q;
    assign alu_x     = d_q;
    assign alu_y     = ir_q[12] ? in_m : a_q;
    assign alu_zx    = ir_q[11];
    assign alu_nx    = ir_q[10];
    assign alu_zy    = ir_q[9];
    assign alu_ny    = ir_q[8];
    assign alu_f     = ir_q[7];
    assign alu_no    = ir_q[6];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        retire  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fire) begin
                    if (!instr[15]) begin
                        a_d    = instr;
                        pc_d   = pc_q + 15'd1;
                        retire = 1'b1;
                    end else begin
                        ir_d    = instr[12:0];
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                // Jump target uses A as held during EXEC, before any writeback
                pc_d   = jmp ? a_q[14:0] : pc_q + 15'd1;
                if (ir_q[5]) a_d = alu_out;
                if (ir_q[4]) d_d = alu_out;
                retire  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            d_q     <= '0;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

`ifdef HACK_CONTROL_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)       retired <= '0;
        else if (retire) retired <= retired + 32'd1;
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_hack_control.sv
// tb_hack_control: directed test-plan sequences plus randomized traffic,
// checked every cycle against an instruction-level model of the Hack CPU.
module tb_hack_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] in_m = '0;
    logic [15:0] out_m;
    logic        write_m;
    logic [14:0] address_m;
    logic [14:0] pc;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic        alu_zr, alu_ng;
`ifdef HACK_CONTROL_RETIRE_CNT_EN
    logic [31:0] retired;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] hack_alu(input logic [15:0] x,
                                             input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] xx, yy, r;
        xx = c[5] ? 16'h0 : x;
        xx = c[4] ? ~xx : xx;
        yy = c[3] ? 16'h0 : y;
        yy = c[2] ? ~yy : yy;
        r  = c[1] ? xx + yy : xx & yy;
        r  = c[0] ? ~r : r;
        return r;
    endfunction

    // External ALU attached to the DUT
    assign alu_out = hack_alu(alu_x, alu_y,
                              {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    assign alu_zr  = (alu_out == 16'h0);
    assign alu_ng  = alu_out[15];

    hack_control dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .in_m(in_m), .out_m(out_m),
        .write_m(write_m), .address_m(address_m), .pc(pc),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy),
        .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
`ifdef HACK_CONTROL_RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

    // Instruction-level model: m_pend means a C-instruction awaits execution
    logic [15:0] m_a = 0, m_d = 0, m_ir = 0;
    logic [14:0] m_pc = 0;
    logic        m_pend = 0;
    logic [31:0] m_ret = 0;

    always @(posedge clk) begin
        logic [15:0] y, r;
        logic        jmp;
        if (reset) begin
            m_a = 0; m_d = 0; m_ir = 0; m_pc = 0; m_pend = 0; m_ret = 0;
        end else if (m_pend) begin
            y   = m_ir[12] ? in_m : m_a;
            r   = hack_alu(m_d, y, m_ir[11:6]);
            jmp = (m_ir[2] && $signed(r) < 0) || (m_ir[1] && r == 0) ||
                  (m_ir[0] && $signed(r) > 0);
            m_pc = jmp ? m_a[14:0] : m_pc + 15'd1;
            if (m_ir[5]) m_a = r;
            if (m_ir[4]) m_d = r;
            m_pend = 0;
            m_ret  = m_ret + 1;
        end else if (instr_valid) begin
            if (!instr[15]) begin
                m_a   = instr;
                m_pc  = m_pc + 15'd1;
                m_ret = m_ret + 1;
            end else begin
                m_ir   = instr;
                m_pend = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic [15:0] y;
        chk("ready", 32'(instr_ready), 32'(!m_pend && !reset));
        chk("write_m", 32'(write_m), 32'(m_pend && m_ir[3] && !reset));
        if (!reset) begin
            chk("pc", 32'(pc), 32'(m_pc));
            chk("address_m", 32'(address_m), 32'(m_a[14:0]));
            chk("alu_x", 32'(alu_x), 32'(m_d));
`ifdef HACK_CONTROL_RETIRE_CNT_EN
            chk("retired", retired, m_ret);
`endif
            if (m_pend) begin
                y = m_ir[12] ? in_m : m_a;
                chk("ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}),
                    32'(m_ir[11:6]));
                chk("alu_y", 32'(alu_y), 32'(y));
                chk("out_m", 32'(out_m), 32'(hack_alu(m_d, y, m_ir[11:6])));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] i);
        instr = i;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    initial begin
        logic [14:0] old_pc;
        reset = 1'b1;
        step();
        chk("ready_in_reset", 32'(instr_ready), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_alu_x", 32'(alu_x), 32'd0);

        issue(16'h0005);
        chk("a5_addr", 32'(address_m), 32'd5);
        chk("a5_pc", 32'(pc), 32'd1);
        chk("a5_ready", 32'(instr_ready), 32'd1);

        issue(16'hEC10);
        chk("da_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}),
            32'b110000);
        chk("da_y", 32'(alu_y), 32'd5);
        chk("da_ready", 32'(instr_ready), 32'd0);
        step();
        chk("da_d", 32'(alu_x), 32'd5);
        chk("da_pc", 32'(pc), 32'd2);

        issue(16'd100);
        issue(16'hE7C8);
        chk("md1_wm", 32'(write_m), 32'd1);
        chk("md1_addr", 32'(address_m), 32'd100);
        chk("md1_out", 32'(out_m), 32'd6);
        step();
        chk("md1_wm_off", 32'(write_m), 32'd0);
        chk("md1_pc", 32'(pc), 32'd4);
        chk("md1_d", 32'(alu_x), 32'd5);

        issue(16'h0000);
        issue(16'hEA90);
        step();
        issue(16'd42);
        issue(16'hE302);
        step();
        chk("jeq_taken", 32'(pc), 32'd42);

        issue(16'd5);
        issue(16'hEC10);
        step();
        issue(16'd42);
        old_pc = m_pc;
        issue(16'hE302);
        step();
        chk("jeq_not", 32'(pc), 32'(old_pc + 15'd1));

        issue(16'd7);
        issue(16'hEC27);
        step();
        chk("jmp_pc", 32'(pc), 32'd7);
        chk("jmp_a", 32'(address_m), 32'd7);

        issue(16'd100);
        issue(16'hE7C8);
        reset = 1'b1;
        #1;
        chk("abort_wm", 32'(write_m), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("abort_pc", 32'(pc), 32'd0);
        chk("abort_a", 32'(address_m), 32'd0);
        chk("abort_d", 32'(alu_x), 32'd0);
        chk("abort_ready", 32'(instr_ready), 32'd1);
`ifdef HACK_CONTROL_RETIRE_CNT_EN
        chk("abort_ret", retired, 32'd0);
`endif

        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 99) == 0);
            instr_valid = ($urandom_range(0, 1) == 1);
            instr       = 16'($urandom);
            if ($urandom_range(0, 2) == 0) instr[15] = 1'b0;
            // Bias toward jumps to exercise wrap and branch paths
            if ($urandom_range(0, 3) == 0) instr[2:0] = 3'b111;
            in_m = 16'($urandom);
            step();
        end
        reset = 1'b0;
        instr_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
